// File: rtl/mod12_hour_tracker_pkg.sv
// Shared definitions for the hour tracker: FSM state encoding and the
// bounds of the mod-12 counter code space.
package mod12_hour_tracker_pkg;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_TRACK = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    localparam logic [3:0] MOD12_MAX   = 4'd11;
    localparam logic [3:0] ILLEGAL_MIN = 4'd12;

    // A counter code is legal when it lies in 0..11.
    function automatic logic is_legal(input logic [3:0] v);
        return (v < ILLEGAL_MIN);
    endfunction

endpackage

// File: rtl/mod12_hour_tracker_bcd.sv
// Combinational map from a mod-12 counter value to the two BCD digits of
// a 12-hour clock face. Counter value 0 is shown as hour 12.
module hour12_to_bcd (
    input  logic [3:0] prev,
    output logic       tens,
    output logic [3:0] ones
);

    // Values 10 and 11 (and 0, shown as 12) need a tens digit of 1.
    always_comb begin
        tens = 1'b0;
        ones = prev;
        if (prev == 4'd0) begin
            tens = 1'b1;
            ones = 4'd2;
        end else if (prev >= 4'd10) begin
            tens = 1'b1;
            ones = prev - 4'd10;
        end
    end

endmodule

// File: rtl/mod12_hour_tracker.sv
// Hour tracker sitting behind a mod-12 loadable counter. Each sampled
// counter value is classified as a step, an 11->0 wrap or a load jump;
// the AM/PM flag toggles on wraps and a registered 12-hour BCD display
// follows the last good value. Illegal codes (12-15) raise err.
module mod12_hour_tracker
    import mod12_hour_tracker_pkg::*;
#(
    parameter bit RESET_PM   = 1'b0,
    parameter bit ERR_STICKY = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] cnt_q,
    input  logic       cnt_valid,
    input  logic       err_clr,
    output logic       disp_tens,
    output logic [3:0] disp_ones,
    output logic       disp_valid,
    output logic       pm,
    output logic       wrap_pulse,
    output logic       jump_pulse,
    output logic       err
);

    state_t     state_reg, state_next;
    logic [3:0] prev_reg,  prev_next;
    logic       tens_reg,  tens_next;
    logic [3:0] ones_reg,  ones_next;
    logic       dv_reg,    dv_next;
    logic       pm_reg,    pm_next;
    logic       wrap_reg,  wrap_next;
    logic       jump_reg,  jump_next;
    logic       err_reg,   err_next;

    // Digits of the incoming sample; they become the display whenever
    // the sample is accepted as the new prev.
    logic       sample_tens;
    logic [3:0] sample_ones;

    hour12_to_bcd u_bcd (
        .prev (cnt_q),
        .tens (sample_tens),
        .ones (sample_ones)
    );

    // State register; every output comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_INIT;
            prev_reg  <= 4'd0;
            tens_reg  <= 1'b0;
            ones_reg  <= 4'd0;
            dv_reg    <= 1'b0;
            pm_reg    <= RESET_PM;
            wrap_reg  <= 1'b0;
            jump_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            prev_reg  <= prev_next;
            tens_reg  <= tens_next;
            ones_reg  <= ones_next;
            dv_reg    <= dv_next;
            pm_reg    <= pm_next;
            wrap_reg  <= wrap_next;
            jump_reg  <= jump_next;
            err_reg   <= err_next;
        end
    end

    // Next-state: classify the sample against prev and update tracking.
    always_comb begin
        state_next = state_reg;
        prev_next  = prev_reg;
        tens_next  = tens_reg;
        ones_next  = ones_reg;
        dv_next    = dv_reg;
        pm_next    = pm_reg;
        wrap_next  = 1'b0;
        jump_next  = 1'b0;
        err_next   = err_reg;

        if (state_reg == ST_ERR) begin
            // Samples are ignored here; only err_clr gets us out, and it
            // wins over a sample arriving in the same cycle.
            if (err_clr) begin
                err_next   = 1'b0;
                state_next = ST_INIT;
            end
        end else begin
            if (err_clr) begin
                err_next = 1'b0;
            end
            if (cnt_valid) begin
                if (!is_legal(cnt_q)) begin
                    // Set beats a simultaneous clear; prev and display hold.
                    err_next = 1'b1;
                    if (ERR_STICKY) begin
                        state_next = ST_ERR;
                    end
                end else if (state_reg == ST_INIT) begin
                    // First good sample seeds prev without any event.
                    prev_next  = cnt_q;
                    tens_next  = sample_tens;
                    ones_next  = sample_ones;
                    dv_next    = 1'b1;
                    state_next = ST_TRACK;
                end else if (cnt_q != prev_reg) begin
                    prev_next = cnt_q;
                    tens_next = sample_tens;
                    ones_next = sample_ones;
                    if (prev_reg == MOD12_MAX && cnt_q == 4'd0) begin
                        wrap_next = 1'b1;
                        pm_next   = ~pm_reg;
                    end else if (cnt_q != prev_reg + 4'd1) begin
                        jump_next = 1'b1;
                    end
                end
            end
        end
    end

    assign disp_tens  = tens_reg;
    assign disp_ones  = ones_reg;
    assign disp_valid = dv_reg;
    assign pm         = pm_reg;
    assign wrap_pulse = wrap_reg;
    assign jump_pulse = jump_reg;
    assign err        = err_reg;

endmodule

// File: tb/tb_mod12_hour_tracker.sv
// Scoreboard bench: two tracker instances (sticky / non-sticky error,
// different reset pm) share stimulus. The driver pushes the reference
// model's expected outputs into per-instance queues; a monitor pops and
// compares one cycle later.
module tb_mod12_hour_tracker;

    typedef struct packed {
        logic       tens;
        logic [3:0] ones;
        logic       dv;
        logic       pm;
        logic       wrap;
        logic       jump;
        logic       err;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cnt_q;
    logic       cnt_valid;
    logic       err_clr;

    logic       d0_tens, d1_tens;
    logic [3:0] d0_ones, d1_ones;
    logic       d0_dv, d1_dv, d0_pm, d1_pm;
    logic       d0_wrap, d1_wrap, d0_jump, d1_jump, d0_err, d1_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    obs_t q0[$];
    obs_t q1[$];

    // Reference model: mode 0 = waiting for first good sample,
    // 1 = tracking, 2 = frozen on error.
    int   m_mode  [2];
    int   m_prev  [2];
    int   m_hour  [2];
    bit   m_dv    [2];
    bit   m_pm    [2];
    bit   m_wrap  [2];
    bit   m_jump  [2];
    bit   m_err   [2];
    bit   m_sticky[2];
    bit   m_rstpm [2];

    mod12_hour_tracker #(.RESET_PM(1'b0), .ERR_STICKY(1'b1)) dut0 (
        .clk(clk), .rst(rst), .cnt_q(cnt_q), .cnt_valid(cnt_valid),
        .err_clr(err_clr), .disp_tens(d0_tens), .disp_ones(d0_ones),
        .disp_valid(d0_dv), .pm(d0_pm), .wrap_pulse(d0_wrap),
        .jump_pulse(d0_jump), .err(d0_err)
    );

    mod12_hour_tracker #(.RESET_PM(1'b1), .ERR_STICKY(1'b0)) dut1 (
        .clk(clk), .rst(rst), .cnt_q(cnt_q), .cnt_valid(cnt_valid),
        .err_clr(err_clr), .disp_tens(d1_tens), .disp_ones(d1_ones),
        .disp_valid(d1_dv), .pm(d1_pm), .wrap_pulse(d1_wrap),
        .jump_pulse(d1_jump), .err(d1_err)
    );

    always #5 clk = ~clk;

    function automatic obs_t dut_obs(int i);
        obs_t o;
        if (i == 0) o = '{d0_tens, d0_ones, d0_dv, d0_pm, d0_wrap, d0_jump, d0_err};
        else        o = '{d1_tens, d1_ones, d1_dv, d1_pm, d1_wrap, d1_jump, d1_err};
        return o;
    endfunction

    // Display digits derived arithmetically from the model's hour value.
    function automatic obs_t model_obs(int i);
        obs_t o;
        int   t;
        int   u;
        t = m_hour[i] / 10;
        u = m_hour[i] % 10;
        o.tens = t[0];
        o.ones = u[3:0];
        o.dv   = m_dv[i];
        o.pm   = m_pm[i];
        o.wrap = m_wrap[i];
        o.jump = m_jump[i];
        o.err  = m_err[i];
        return o;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0;
            m_prev[i] = 0;
            m_hour[i] = 0;   // display reads 0,0 until the first good sample
            m_dv[i]   = 1'b0;
            m_pm[i]   = m_rstpm[i];
            m_wrap[i] = 1'b0;
            m_jump[i] = 1'b0;
            m_err[i]  = 1'b0;
        end
    endtask

    task automatic model_step(int i, bit valid, int v, bit clr);
        m_wrap[i] = 1'b0;
        m_jump[i] = 1'b0;
        if (m_mode[i] == 2) begin
            if (clr) begin
                m_err[i]  = 1'b0;
                m_mode[i] = 0;
            end
        end else begin
            if (clr) m_err[i] = 1'b0;
            if (valid) begin
                if (v >= 12) begin
                    m_err[i] = 1'b1;
                    if (m_sticky[i]) m_mode[i] = 2;
                end else if (m_mode[i] == 0) begin
                    m_prev[i] = v;
                    m_hour[i] = (v == 0) ? 12 : v;
                    m_dv[i]   = 1'b1;
                    m_mode[i] = 1;
                end else if (v != m_prev[i]) begin
                    if (m_prev[i] == 11 && v == 0) begin
                        m_wrap[i] = 1'b1;
                        m_pm[i]   = ~m_pm[i];
                    end else if (v != m_prev[i] + 1) begin
                        m_jump[i] = 1'b1;
                    end
                    m_prev[i] = v;
                    m_hour[i] = (v == 0) ? 12 : v;
                end
            end
        end
    endtask

    task automatic check_obs(string name, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got tens=%0d ones=%0d dv=%0d pm=%0d wrap=%0d jump=%0d err=%0d want tens=%0d ones=%0d dv=%0d pm=%0d wrap=%0d jump=%0d err=%0d",
                     name, cyc, got.tens, got.ones, got.dv, got.pm, got.wrap, got.jump, got.err,
                     exp.tens, exp.ones, exp.dv, exp.pm, exp.wrap, exp.jump, exp.err);
        end
    endtask

    // One cycle of stimulus: drive on the falling edge, predict, enqueue.
    task automatic drive(bit valid, int v, bit clr);
        logic [3:0] v4;
        @(negedge clk);
        v4        = v[3:0];
        cnt_valid = valid;
        cnt_q     = v4;
        err_clr   = clr;
        cyc++;
        for (int i = 0; i < 2; i++) model_step(i, valid, v, clr);
        q0.push_back(model_obs(0));
        q1.push_back(model_obs(1));
        $display("txn %0d valid=%0d v=%0d clr=%0d", cyc, valid, v, clr);
    endtask

    // Monitor: outputs are registered, so each queued expectation is
    // due just after the next rising edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            if (q0.size() > 0) check_obs("dut0_sticky", dut_obs(0), q0.pop_front());
            if (q1.size() > 0) check_obs("dut1_nonsticky", dut_obs(1), q1.pop_front());
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        int v;
        int nxt;
        m_sticky[0] = 1'b1; m_rstpm[0] = 1'b0;
        m_sticky[1] = 1'b0; m_rstpm[1] = 1'b1;
        model_reset();
        rst = 1'b1; cnt_q = 4'd0; cnt_valid = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_obs("reset_dut0", dut_obs(0), model_obs(0));
        check_obs("reset_dut1", dut_obs(1), model_obs(1));
        @(negedge clk);
        rst = 1'b0;

        // Seed, step, wrap twice, jump and repeat-sample.
        drive(1, 0, 0); drive(1, 1, 0); drive(1, 2, 0);
        drive(0, 0, 0);
        drive(1, 10, 0); drive(1, 11, 0); drive(1, 0, 0); drive(1, 1, 0);
        drive(1, 10, 0); drive(1, 11, 0); drive(1, 0, 0);
        drive(1, 3, 0); drive(1, 8, 0); drive(1, 8, 0);
        drive(1, 11, 0); drive(1, 5, 0); drive(1, 0, 0); drive(1, 11, 0);

        // Error handling.
        drive(1, 5, 0); drive(1, 13, 0); drive(1, 6, 0);
        drive(1, 7, 1); drive(1, 7, 0); drive(0, 0, 1);
        drive(1, 14, 1); drive(0, 0, 0); drive(0, 0, 1); drive(1, 15, 0);
        drive(0, 0, 1); drive(1, 9, 0); drive(1, 12, 0); drive(1, 10, 1);
        drive(0, 0, 1); drive(1, 10, 0);

        // Get dut0 into PM, then reset asynchronously between edges.
        drive(1, 11, 0); drive(1, 0, 0); drive(1, 1, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check_obs("async_reset_dut0", dut_obs(0), model_obs(0));
        check_obs("async_reset_dut1", dut_obs(1), model_obs(1));
        q0.delete();
        q1.delete();
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic biased toward counting steps.
        for (int n = 0; n < 300; n++) begin
            nxt = (m_prev[0] == 11) ? 0 : m_prev[0] + 1;
            r   = $urandom_range(0, 9);
            if (r < 6)      v = nxt;
            else if (r < 7) v = m_prev[0];
            else if (r < 9) v = $urandom_range(0, 11);
            else            v = $urandom_range(12, 15);
            drive($urandom_range(0, 9) < 8, v, $urandom_range(0, 9) == 0);
        end
        drive(0, 0, 0);
        drive(0, 0, 0);
        @(negedge clk);

        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            failures++;
            $display("FAIL queue_drain got %0d/%0d pending want 0/0", q0.size(), q1.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mod12_hour_tracker.md
Name: mod12_hour_tracker

Overview:
- Downstream consumer of the 4-bit mod-12 loadable up counter.
- Samples the counter value and classifies each change as a step, a wrap (11->0) or a load jump.
- Maintains the AM/PM flag and a registered 12-hour BCD display (0 shown as 12).
- Flags illegal counter codes (12-15).

Parameters:
- RESET_PM, 0: value of pm after reset.
- ERR_STICKY, 1: 1 = an illegal code freezes tracking until err_clr; 0 = the bad sample is dropped and tracking continues.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- cnt_q  in  4  counter value from the mod-12 counter.
- cnt_valid  in  1  cnt_q is sampled on this cycle.
- err_clr  in  1  clears err; leaves ERR state.
- disp_tens  out  1  BCD tens digit of the 12-hour display (0 or 1).
- disp_ones  out  4  BCD ones digit (0-9).
- disp_valid  out  1  display holds a good sample.
- pm  out  1  AM(0)/PM(1) flag.
- wrap_pulse  out  1  one-cycle pulse on an 11->0 step.
- jump_pulse  out  1  one-cycle pulse on a non-sequential change (load detected).
- err  out  1  illegal code seen.

Behaviour:
- Reset (async, active-high), effective immediately regardless of state:
  - state = INIT, prev = 0.
  - disp_tens = 0, disp_ones = 0, disp_valid = 0.
  - pm = RESET_PM.
  - wrap_pulse = 0, jump_pulse = 0, err = 0.
- All outputs are registered. Latency: a sample on cycle N is reflected on outputs at cycle N+1.
- Pulses are high for exactly one cycle. Both pulses are 0 on any cycle without a classified sample.
- States: INIT, TRACK, ERR.
- INIT, on cnt_valid:
  - legal v (0-11): prev = v, display updated, disp_valid = 1, go TRACK. No pulses, pm unchanged.
  - illegal v: err = 1; go ERR if ERR_STICKY, else stay in INIT.
- TRACK, on cnt_valid with v, prev p:
  - v >= 12: err = 1, prev and display held; go ERR if ERR_STICKY, else stay in TRACK.
  - v == p: no event, nothing changes.
  - v == p+1 (p <= 10): prev = v, display updated.
  - p == 11 and v == 0: prev = 0, display updated, wrap_pulse = 1, pm toggles.
  - any other legal v: prev = v, display updated, jump_pulse = 1, pm unchanged. This includes 11->5 and 0->11.
- ERR:
  - cnt_valid is ignored; display, pm and disp_valid hold their last good values.
  - err_clr: err = 0, go INIT (pm kept, disp_valid kept).
- err_clr outside ERR: clears err.
  - If a same-cycle sample is illegal, set wins (err = 1).
  - In ERR, err_clr beats a same-cycle cnt_valid; that sample is dropped.
- Display mapping:
  - h = (prev == 0) ? 12 : prev.
  - disp_tens = (h >= 10); disp_ones = h - 10*disp_tens.
  - Examples: 0 -> 1,2; 9 -> 0,9; 10 -> 1,0; 11 -> 1,1.
- No cnt_valid: all state holds, pulses are 0.

Decomposition:
- Shared package: state encoding (INIT=2'd0, TRACK=2'd1, ERR=2'd2), MOD12_MAX = 4'd11, ILLEGAL_MIN = 4'd12.
- One sub-module, hour12_to_bcd: a combinational 4-bit prev -> {tens, ones} map, reused by future display stages.
- FSM and pulse logic live in the top level.

Test Plan:
- Reset, then samples 0,1,2 -> disp_valid = 1 at cycle after first sample; display 12, 01, 02; no pulses; pm = 0.
- Samples 10, 11, 0, 1 from TRACK -> wrap_pulse = 1 only in the cycle after the 0 sample; pm 0->1; display 10, 11, 12, 01. Repeat the wrap -> pm back to 0.
- TRACK at 3, sample 8 -> jump_pulse = 1 for one cycle, display 08, pm unchanged. Sample 8 again -> no pulse.
- ERR_STICKY = 1: TRACK at 5, sample 13 -> err = 1, display held 05. Sample 6 is ignored. err_clr plus sample 7 in the same cycle -> INIT, sample dropped. Next sample 7 -> TRACK, display 07, no jump_pulse.
- ERR_STICKY = 0: sample 15 -> err = 1, tracking continues. Next sample 6 after prev 5 -> normal step. err_clr -> err = 0.
- Assert rst mid-TRACK with pm = 1 (asynchronously, between edges) -> all outputs go to reset values immediately; pm = RESET_PM.
